clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/clk_div_chan.sv | 72 +++++++
 rtl/clk_div_multi.sv | 56 +++++
 tb/tb_clk_div_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Ratio values are carried in a container wide enough for the largest counter width.
package clk_div_pkg;

  localparam int RATIO_W_MAX = 16;

  typedef logic [RATIO_W_MAX-1:0] ratio_t;

  // A stored ratio of zero behaves exactly like divide-by-one.
  localparam ratio_t RATIO_ZERO_MAP = ratio_t'(1);

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic ratio_t eff_ratio(input ratio_t r);
    return (r == '0) ? RATIO_ZERO_MAP : r;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: phase counter, active/shadow ratio, pending flag,
// registered divided clock and wrap strobe.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int W         = 8,
  parameter int DEF_RATIO = 2
) (
  input  logic         clkIn,
  input  logic         rst,
  input  logic         sync,
  input  logic         i_load,
  input  logic [W-1:0] i_ratio,
  output logic         o_clk,
  output logic         o_strobe,
  output logic [W-1:0] o_cnt,
  output logic         o_pending
);

  localparam logic [W-1:0] DEF_R   = W'(DEF_RATIO);
  localparam logic         DEF_CLK = (DEF_RATIO >= 2);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_ratio;
  logic [W-1:0] r_shadow;
  logic         r_pending;
  logic         r_clk;

  logic [W-1:0] w_eff;
  logic [W-1:0] w_last;
  logic [W-1:0] w_cnt_next;
  logic [W-1:0] w_ratio_next;
  logic [W-1:0] w_half_next;
  logic         w_wrap;
  logic         w_apply;
  logic         w_pending_next;

  assign w_eff  = W'(eff_ratio(ratio_t'(r_ratio)));
  assign w_last = w_eff - W'(1);
  assign w_wrap = (r_cnt == w_last);

  // A new ratio only lands on a period boundary (or a forced sync), so phases never get clipped.
  assign w_apply        = r_pending & (sync | w_wrap);
  assign w_ratio_next   = w_apply ? r_shadow : r_ratio;
  assign w_cnt_next     = (sync | w_wrap) ? '0 : r_cnt + W'(1);
  assign w_half_next    = W'(eff_ratio(ratio_t'(w_ratio_next))) >> 1;
  assign w_pending_next = i_load | (r_pending & ~w_apply);

  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_ratio   <= DEF_R;
      r_shadow  <= DEF_R;
      r_pending <= 1'b0;
      r_clk     <= DEF_CLK;
    end else begin
      r_cnt     <= w_cnt_next;
      r_ratio   <= w_ratio_next;
      r_pending <= w_pending_next;
      r_clk     <= (w_cnt_next < w_half_next);
      if (i_load) begin
        r_shadow <= i_ratio;
      end
    end
  end

  assign o_clk     = r_clk;
  assign o_strobe  = w_wrap & ~sync;
  assign o_cnt     = r_cnt;
  assign o_pending = r_pending;

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable clock dividers sharing one clock, a sync
// request and a single ratio-load port with per-channel backpressure.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int W         = 8,
  parameter int DEF_RATIO = 2
) (
  input  logic                        clkIn,
  input  logic                        rst,
  input  logic                        sync,
  input  logic                        cfgValid,
  input  logic [ch_idx_w(NCH)-1:0]    cfgCh,
  input  logic [W-1:0]                cfgRatio,
  output logic                        cfgReady,
  output logic [NCH-1:0]              clkOut,
  output logic [NCH-1:0]              strobe,
  output logic [NCH*W-1:0]            cntOut,
  output logic [NCH-1:0]              pending
);

  localparam int CW = ch_idx_w(NCH);

  logic [NCH-1:0] w_sel;
  logic [NCH-1:0] w_load;
  logic           w_ready;

  // An out-of-range channel selects nothing, so it can never be ready.
  assign w_ready  = |(w_sel & ~pending);
  assign cfgReady = w_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign w_sel[gi]  = (cfgCh == CW'(gi));
      assign w_load[gi] = cfgValid & w_ready & w_sel[gi];

      clk_div_chan #(
        .W         (W),
        .DEF_RATIO (DEF_RATIO)
      ) u_chan (
        .clkIn     (clkIn),
        .rst       (rst),
        .sync      (sync),
        .i_load    (w_load[gi]),
        .i_ratio   (cfgRatio),
        .o_clk     (clkOut[gi]),
        .o_strobe  (strobe[gi]),
        .o_cnt     (cntOut[gi*W +: W]),
        .o_pending (pending[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: the driver advances a period/position
// model and queues expected outputs; a negedge monitor pops and compares.
module tb_clk_div_multi;

  localparam int NCH = 2;
  localparam int W   = 8;
  localparam int DEF = 4;

  logic             clkIn    = 1'b0;
  logic             rst      = 1'b0;
  logic             sync     = 1'b0;
  logic             cfgValid = 1'b0;
  logic [0:0]       cfgCh    = '0;
  logic [W-1:0]     cfgRatio = '0;
  logic             cfgReady;
  logic [NCH-1:0]   clkOut;
  logic [NCH-1:0]   strobe;
  logic [NCH*W-1:0] cntOut;
  logic [NCH-1:0]   pending;

  always #5 clkIn = ~clkIn;

  clk_div_multi #(.NCH(NCH), .W(W), .DEF_RATIO(DEF)) dut (
    .clkIn    (clkIn),
    .rst      (rst),
    .sync     (sync),
    .cfgValid (cfgValid),
    .cfgCh    (cfgCh),
    .cfgRatio (cfgRatio),
    .cfgReady (cfgReady),
    .clkOut   (clkOut),
    .strobe   (strobe),
    .cntOut   (cntOut),
    .pending  (pending)
  );

  typedef struct packed {
    logic [NCH-1:0]   strobe;
    logic [NCH-1:0]   clk;
    logic [NCH-1:0]   pend;
    logic [NCH*W-1:0] cnt;
    logic             rdy;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: each channel sits at position m_pos inside a period of eff(m_ratio) cycles.
  int m_ratio[NCH];
  int m_shadow[NCH];
  int m_pos[NCH];
  bit m_pend[NCH];

  function automatic int eff(input int r);
    return (r == 0) ? 1 : r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_ratio[k]  = DEF;
      m_shadow[k] = DEF;
      m_pos[k]    = 0;
      m_pend[k]   = 1'b0;
    end
  endtask

  // Advance the model across one rising edge using the inputs held during the past cycle.
  task automatic model_edge();
    bit acc;
    int e;
    if (!rst) begin
      model_reset();
    end else begin
      acc = cfgValid && (int'(cfgCh) < NCH) && !m_pend[cfgCh];
      for (int k = 0; k < NCH; k++) begin
        e = eff(m_ratio[k]);
        if (m_pend[k] && (sync || m_pos[k] == e - 1)) begin
          m_ratio[k] = m_shadow[k];
          m_pend[k]  = 1'b0;
        end
        m_pos[k] = sync ? 0 : (m_pos[k] + 1) % e;
        if (acc && int'(cfgCh) == k) begin
          m_shadow[k] = int'(cfgRatio);
          m_pend[k]   = 1'b1;
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_t x;
    int e;
    x = '0;
    for (int k = 0; k < NCH; k++) begin
      e = eff(m_ratio[k]);
      x.strobe[k]      = (m_pos[k] == e - 1) && !sync;
      x.clk[k]         = (m_pos[k] < e / 2);
      x.pend[k]        = m_pend[k];
      x.cnt[k*W +: W]  = W'(m_pos[k]);
    end
    x.rdy = (int'(cfgCh) < NCH) && !m_pend[cfgCh];
    sb_q.push_back(x);
  endtask

  task automatic cyc(input bit s, input bit v, input int ch, input int r, input bit rs);
    @(posedge clkIn);
    #1;
    model_edge();
    rst      = rs;
    sync     = s;
    cfgValid = v;
    cfgCh    = 1'(ch);
    cfgRatio = W'(r);
    if (!rs) begin
      model_reset();
      $display("[%0t] reset asserted", $time);
    end else begin
      if (v && !m_pend[ch]) $display("[%0t] load ch%0d ratio %0d accepted", $time, ch, r);
      else if (v)           $display("[%0t] load ch%0d ratio %0d refused", $time, ch, r);
      if (s)                $display("[%0t] sync", $time);
    end
    push_expected();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  // Idle until the channel's position equals tgt, so the next cyc() acts at position tgt+1.
  task automatic wait_pos(input int k, input int tgt, input string name);
    int guard;
    guard = 0;
    while (m_pos[k] != tgt && guard < 300) begin
      idle(1);
      guard++;
    end
    if (guard >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for position %0d", name, tgt);
    end
  endtask

  task automatic wait_not_pending(input int k, input string name);
    int guard;
    guard = 0;
    while (m_pend[k] && guard < 300) begin
      idle(1);
      guard++;
    end
    if (guard >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for pending to clear", name);
    end
  endtask

  initial begin
    forever begin
      @(negedge clkIn);
      if (sb_q.size() > 0) begin
        mon_exp = sb_q.pop_front();
        chk("strobe",   32'(strobe),   32'(mon_exp.strobe));
        chk("clkOut",   32'(clkOut),   32'(mon_exp.clk));
        chk("pending",  32'(pending),  32'(mon_exp.pend));
        chk("cntOut",   32'(cntOut),   32'(mon_exp.cnt));
        chk("cfgReady", 32'(cfgReady), 32'(mon_exp.rdy));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  bit s_r, v_r, rs_r;
  int ch_r, rat_r;

  initial begin
    model_reset();

    // Reset state, then free-running at the default ratio of 4.
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
    idle(14);

    // ch0 -> 6 loaded at cnt=1: current period of 4 completes first.
    wait_pos(0, 0, "ch0_cnt1");
    cyc(1'b0, 1'b1, 0, 6, 1'b1);
    idle(14);

    // ch1 -> 3 loaded in its own wrap cycle, then a refused second load.
    wait_pos(1, 2, "ch1_wrap");
    cyc(1'b0, 1'b1, 1, 3, 1'b1);
    cyc(1'b0, 1'b1, 1, 5, 1'b1);
    idle(12);

    // sync with ch0 at cnt=2, then watch realignment.
    wait_pos(0, 1, "ch0_cnt2");
    cyc(1'b1, 1'b0, 0, 0, 1'b1);
    idle(26);

    // Ratio 0 and ratio 1 both behave as divide-by-one.
    cyc(1'b0, 1'b1, 0, 0, 1'b1);
    wait_not_pending(0, "ch0_r0");
    idle(4);
    cyc(1'b0, 1'b1, 0, 1, 1'b1);
    wait_not_pending(0, "ch0_r1");
    idle(4);
    cyc(1'b1, 1'b0, 0, 0, 1'b1);
    idle(3);

    // Load during a sync cycle stays pending.
    cyc(1'b1, 1'b1, 1, 2, 1'b1);
    idle(6);

    // Reset mid-period with a load pending.
    cyc(1'b0, 1'b1, 1, 7, 1'b1);
    idle(1);
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
    idle(12);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      s_r   = ($urandom_range(31) == 0);
      v_r   = ($urandom_range(3) == 0);
      ch_r  = int'($urandom_range(NCH - 1));
      rat_r = ($urandom_range(7) == 0) ? int'($urandom_range(40)) : int'($urandom_range(9));
      rs_r  = ($urandom_range(299) != 0);
      cyc(s_r, v_r, ch_r, rat_r, rs_r);
    end
    idle(4);

    @(negedge clkIn);
    @(negedge clkIn);
    #1;
    chk("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
